// File: rtl/tid_stamp_fifo.sv
// TX request ingress: stamps each accepted header with a monotonically increasing
// transaction ID, buffers it, and releases it through a registered one-cycle read.
`ifndef CCIP_TX_HDR_WIDTH
`define CCIP_TX_HDR_WIDTH 74
`endif

module tid_stamp_fifo #(
    parameter int HDR_WIDTH    = `CCIP_TX_HDR_WIDTH,
    parameter int TID_WIDTH    = 32,
    parameter int DEPTH        = 16,   // power of two, >= 4
    parameter int AFULL_THRESH = 12    // 1..DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [HDR_WIDTH-1:0]       meta_in,
    input  logic                       rd_en,
    output logic                       valid_out,
    output logic [HDR_WIDTH-1:0]       meta_out,
    output logic [TID_WIDTH-1:0]       tid_out,
    output logic [TID_WIDTH-1:0]       tid_next,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    typedef struct packed {
        logic [HDR_WIDTH-1:0] meta;
        logic [TID_WIDTH-1:0] tid;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Both accept terms use the registered flags, so a pop never rescues a
    // write into a full FIFO and a write never feeds a pop on an empty one.
    assign wr_acc = valid_in & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Data entries carry no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= '{meta: meta_in, tid: tid_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tid_next    <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr   <= wr_ptr + AW'(1);
                tid_next <= tid_next + TID_WIDTH'(1);
            end
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            full        <= (count_nxt == DEPTH_C);
            almost_full <= (count_nxt >= AFULL_C);
            empty       <= (count_nxt == '0);
            if (valid_in && full) overflow  <= 1'b1;
            if (rd_en && empty)   underflow <= 1'b1;
        end
    end

    // Output registers hold their last value between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            meta_out  <= '0;
            tid_out   <= '0;
        end else begin
            valid_out <= rd_acc;
            if (rd_acc) begin
                meta_out <= mem[rd_ptr].meta;
                tid_out  <= mem[rd_ptr].tid;
            end
        end
    end
endmodule

// File: tb/tb_tid_stamp_fifo.sv
// Directed bench for tid_stamp_fifo: scoreboard of stamped entries, checked every cycle.
module tb_tid_stamp_fifo;
    localparam int HW = 16;
    localparam int TW = 32;
    localparam int D  = 16;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid_in = 1'b0;
    logic [HW-1:0] meta_in = '0;
    logic          rd_en = 1'b0;
    logic          valid_out;
    logic [HW-1:0] meta_out;
    logic [TW-1:0] tid_out;
    logic [TW-1:0] tid_next;
    logic [4:0]    count;
    logic          full, almost_full, empty, overflow, underflow;

    logic          w_valid_in = 1'b0;
    logic [HW-1:0] w_meta_in = '0;
    logic          w_rd_en = 1'b0;
    logic          w_valid_out;
    logic [HW-1:0] w_meta_out;
    logic [3:0]    w_tid_out;
    logic [3:0]    w_tid_next;
    logic [4:0]    w_count;
    logic          w_full, w_afull, w_empty, w_ovf, w_udf;

    always #5 clk = ~clk;

    tid_stamp_fifo #(.HDR_WIDTH(HW), .TID_WIDTH(TW), .DEPTH(D), .AFULL_THRESH(AF)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .meta_in(meta_in), .rd_en(rd_en),
        .valid_out(valid_out), .meta_out(meta_out), .tid_out(tid_out), .tid_next(tid_next),
        .count(count), .full(full), .almost_full(almost_full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    tid_stamp_fifo #(.HDR_WIDTH(HW), .TID_WIDTH(4), .DEPTH(D), .AFULL_THRESH(AF)) u_w4 (
        .clk(clk), .rst_n(rst_n), .valid_in(w_valid_in), .meta_in(w_meta_in), .rd_en(w_rd_en),
        .valid_out(w_valid_out), .meta_out(w_meta_out), .tid_out(w_tid_out), .tid_next(w_tid_next),
        .count(w_count), .full(w_full), .almost_full(w_afull), .empty(w_empty),
        .overflow(w_ovf), .underflow(w_udf)
    );

    typedef struct packed {
        logic [HW-1:0] meta;
        logic [TW-1:0] tid;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            mcount = 0;
    logic [TW-1:0] mtid = '0;
    logic          movf = 1'b0;
    logic          mudf = 1'b0;
    logic [HW-1:0] last_meta = '0;
    logic [TW-1:0] last_tid = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("meta_out", 64'(meta_out), 64'(last_meta));
        chk("tid_out", 64'(tid_out), 64'(last_tid));
        chk("count", 64'(count), 64'(mcount));
        chk("tid_next", 64'(tid_next), 64'(mtid));
        chk("full", 64'(full), 64'(mcount == D));
        chk("almost_full", 64'(almost_full), 64'(mcount >= AF));
        chk("empty", 64'(empty), 64'(mcount == 0));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("underflow", 64'(underflow), 64'(mudf));
    endtask

    // One clock of stimulus; accepted writes enter the scoreboard, accepted
    // pops retire its head and must appear on the output one edge later.
    task automatic cycle(input logic v, input logic [HW-1:0] m, input logic r);
        logic wr, rd;
        exp_t e;
        valid_in = v; meta_in = m; rd_en = r;
        wr = v && (mcount < D);
        rd = r && (mcount != 0);
        if (wr) begin sb.push_back('{meta: m, tid: mtid}); mtid = mtid + 1; end
        if (v && !wr) movf = 1'b1;
        if (r && !rd) mudf = 1'b1;
        mcount = mcount + int'(wr) - int'(rd);
        @(posedge clk); #1;
        valid_in = 1'b0; rd_en = 1'b0;
        chk("valid_out", 64'(valid_out), 64'(rd));
        if (rd) begin
            e = sb.pop_front();
            last_meta = e.meta;
            last_tid  = e.tid;
        end
        chk_state();
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        mcount = 0; mtid = '0; movf = 1'b0; mudf = 1'b0;
        last_meta = '0; last_tid = '0;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Three writes then three back-to-back pops
        cycle(1'b1, 16'hA0A0, 1'b0);
        cycle(1'b1, 16'hB0B0, 1'b0);
        cycle(1'b1, 16'hC0C0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Fill past capacity: flags walk through almost_full and full, write 17 drops
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, HW'(16'h1000 + i), 1'b0);
        chk("fill_tid_next", 64'(tid_next), 64'd16);

        // Full with write+pop: write dropped, tid 0 popped, count 15
        cycle(1'b1, 16'hDEAD, 1'b1);
        chk("full_pop_tid", 64'(tid_out), 64'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);

        // Empty with write+pop: underflow, entry still stored
        do_reset();
        cycle(1'b1, 16'h4444, 1'b1);
        chk("udf_count", 64'(count), 64'd1);
        cycle(1'b0, '0, 1'b1);
        chk("udf_next_tid", 64'(tid_out), 64'd0);

        // 4-bit TID wrap through the narrow instance
        w_valid_in = 1'b1; w_meta_in = 16'h0100;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            w_valid_in = (k < 19); w_meta_in = HW'(16'h0101 + k); w_rd_en = 1'b1;
            @(posedge clk); #1;
            chk("w4_valid_out", 64'(w_valid_out), 64'd1);
            chk("w4_tid_out", 64'(w_tid_out), 64'(k % 16));
            chk("w4_meta_out", 64'(w_meta_out), 64'(16'h0100 + k));
            chk("w4_count", 64'(w_count), (k < 19) ? 64'd1 : 64'd0);
        end
        w_valid_in = 1'b0; w_rd_en = 1'b0;
        chk("w4_tid_next", 64'(w_tid_next), 64'd4);
        chk("w4_empty", 64'(w_empty), 64'd1);
        chk("w4_full", 64'(w_full), 64'd0);
        chk("w4_afull", 64'(w_afull), 64'd0);
        chk("w4_overflow", 64'(w_ovf), 64'd0);
        chk("w4_underflow", 64'(w_udf), 64'd0);

        // Asynchronous reset with entries buffered, then tid restarts at 0
        for (int i = 0; i < 5; i++) cycle(1'b1, HW'(16'h5000 + i), 1'b0);
        do_reset();
        cycle(1'b1, 16'h6666, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("post_rst_tid", 64'(tid_out), 64'd0);
        chk("post_rst_meta", 64'(meta_out), 64'h6666);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
